// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2
// ReLU followed by 2x2 / stride-2 max-pooling on a raster-order float32
// feature-map stream. One instance per filter; the input cannot be stalled.
// Because every value is non-negative after ReLU, the float32 maximum is an
// unsigned compare of the bit patterns, so no floating-point unit is needed.
// The pair maximum of each even row is parked in a line buffer. The matching
// odd row reads it back and produces one pooled output per column pair.

module relu_maxpool2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int COL_W    = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W    = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int LB_DEPTH = WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    // Negative values and -0.0 collapse to +0.0; NaN inputs are not expected.
    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? '0 : x;
    endfunction

    // Maximum of two non-negative floats, compared as unsigned bit patterns.
    function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] linebuf [LB_DEPTH];

    logic [DATA_WIDTH-1:0] r_p0;
    logic [DATA_WIDTH-1:0] pm_p0;
    logic [DATA_WIDTH-1:0] lb_rd_p0;
    logic [LB_AW-1:0]      lb_idx_p0;
    logic                  last_col_p0;
    logic                  last_row_p0;
    logic                  lb_wr_p0;
    logic                  emit_p0;

    // ---- stage p0: ReLU, horizontal pair max, line-buffer access decode ----

    // Combinational datapath for the sample currently on data_in.
    always_comb begin
        r_p0        = relu(data_in);
        pm_p0       = umax(hold, r_p0);
        lb_idx_p0   = LB_AW'(col >> 1);
        lb_rd_p0    = linebuf[lb_idx_p0];
        last_col_p0 = (col == COL_W'(WIDTH - 1));
        last_row_p0 = (row == ROW_W'(HEIGHT - 1));
        lb_wr_p0    = valid_in && col[0] && !row[0];
        emit_p0     = valid_in && col[0] && row[0];
    end

    // ---- stage p1: registered counters, pair hold and pooled output ----

    // Raster position counters, left-pair hold register and output registers.
    // Row/frame wrap and the last output of a frame share the same edge, so a
    // new frame can begin on the very next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else begin
            valid_out  <= emit_p0;
            frame_done <= emit_p0 && last_col_p0 && last_row_p0;
            if (emit_p0) begin
                data_out <= umax(lb_rd_p0, pm_p0);
            end
            if (valid_in) begin
                if (!col[0]) begin
                    hold <= r_p0;
                end
                if (last_col_p0) begin
                    col <= '0;
                    row <= last_row_p0 ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffer: written on even rows only, read on odd rows only, so each
    // accepted sample makes at most one access. No reset: every entry is
    // written in an even row before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_wr_p0) begin
            linebuf[lb_idx_p0] <= pm_p0;
        end
    end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Testbench for relu_maxpool2x2: a 2x2 instance driven from a vector table
// plus hand-written multi-cycle sequences, and a 112x112 instance driven
// with full frames checked against the closed-form expected output stream.
`timescale 1ns/1ps

module tb_relu_maxpool2x2;

    localparam int BW = 112;
    localparam int BH = 112;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small 2x2 instance
    logic        rst_s, vin_s, vout_s, fd_s;
    logic [31:0] din_s, dout_s;
    // full-size instance
    logic        rst_b, vin_b, vout_b, fd_b;
    logic [31:0] din_b, dout_b;

    relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2)) dut_s (
        .clk(clk), .rst(rst_s), .valid_in(vin_s), .data_in(din_s),
        .valid_out(vout_s), .data_out(dout_s), .frame_done(fd_s)
    );

    relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(BW), .HEIGHT(BH)) dut_b (
        .clk(clk), .rst(rst_b), .valid_in(vin_b), .data_in(din_b),
        .valid_out(vout_b), .data_out(dout_b), .frame_done(fd_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0][31:0] d;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[7];

    // bench-side model of the full-size instance
    int          brow, bcol;
    logic [31:0] exp_b;
    int          out_cnt, fd_cnt;

    // positive integer to float32 bit pattern (exact for values below 2^24)
    function automatic logic [31:0] int2f(input int n);
        int          e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 31; i++) if (((n >> i) & 1) == 1) e = i;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got vout/fd/data=%0b/%0b/%h, expected %0b/%0b/%h",
                     name, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic step_s(input logic v, input logic [31:0] d);
        vin_s = v;
        din_s = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v);
        logic        ev, efd;
        vin_b = v;
        din_b = v ? int2f(brow * BW + bcol) : $urandom;
        @(posedge clk);
        #1;
        ev  = v && (brow % 2 == 1) && (bcol % 2 == 1);
        efd = ev && (brow == BH - 1) && (bcol == BW - 1);
        if (ev) exp_b = int2f(brow * BW + bcol);
        check("big_stream", {vout_b, fd_b, dout_b}, {ev, efd, exp_b});
        out_cnt += int'(vout_b);
        fd_cnt  += int'(fd_b);
        if (v) begin
            if (bcol == BW - 1) begin
                bcol = 0;
                brow = (brow == BH - 1) ? 0 : brow + 1;
            end else begin
                bcol++;
            end
        end
    endtask

    initial begin
        logic [31:0] prev;

        vecs[0] = '{d: '{32'h80000000, 32'hBF000000, 32'hC0000000, 32'hBF800000}, exp: 32'h00000000};
        vecs[1] = '{d: '{32'hC0E00000, 32'h40000000, 32'h40600000, 32'h3F800000}, exp: 32'h40600000};
        vecs[2] = '{d: '{32'h40800000, 32'h40000000, 32'h3F800000, 32'h40A00000}, exp: 32'h40A00000};
        vecs[3] = '{d: '{32'h41000000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, exp: 32'h41000000};
        vecs[4] = '{d: '{32'h3E800000, 32'hC0400000, 32'h3F000000, 32'hBF800000}, exp: 32'h3F000000};
        vecs[5] = '{d: '{32'h00000000, 32'h80000005, 32'h00000001, 32'h7F7FFFFF}, exp: 32'h7F7FFFFF};
        vecs[6] = '{d: '{32'h00000002, 32'h80000000, 32'h00000000, 32'h00000001}, exp: 32'h00000002};

        rst_s = 1'b0; vin_s = 1'b0; din_s = '0;
        rst_b = 1'b0; vin_b = 1'b0; din_b = '0;
        brow = 0; bcol = 0; exp_b = '0; out_cnt = 0; fd_cnt = 0;

        // reset held with valid_in toggling: outputs stay cleared
        #1;
        for (int i = 0; i < 6; i++) begin
            vin_b = ~vin_b;
            din_b = $urandom;
            step_s(i[0], $urandom);
            check("reset_small", {vout_s, fd_s, dout_s}, 34'h0);
            check("reset_big", {vout_b, fd_b, dout_b}, 34'h0);
        end
        rst_s = 1'b1;
        rst_b = 1'b1;
        vin_b = 1'b0;

        // table-driven 2x2 frames, applied back to back
        prev = 32'h0;
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 3; k++) begin
                step_s(1'b1, vecs[v].d[k]);
                check($sformatf("vec%0d_s%0d", v, k), {vout_s, fd_s, dout_s}, {2'b00, prev});
            end
            step_s(1'b1, vecs[v].d[3]);
            check($sformatf("vec%0d_out", v), {vout_s, fd_s, dout_s}, {2'b11, vecs[v].exp});
            prev = vecs[v].exp;
        end
        step_s(1'b0, 32'hDEADBEEF);
        check("hold_after_frame", {vout_s, fd_s, dout_s}, {2'b00, prev});

        // gaps inside a frame are ignored
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 3; g++) begin
                step_s(1'b0, 32'h7F000000);
                check("gap_idle", {vout_s, fd_s, dout_s}, {2'b00, prev});
            end
            case (k)
                0: step_s(1'b1, 32'h3F800000);
                1: step_s(1'b1, 32'hBF800000);
                2: step_s(1'b1, 32'h40400000);
                default: step_s(1'b1, 32'h3F000000);
            endcase
        end
        check("gap_out", {vout_s, fd_s, dout_s}, {2'b11, 32'h40400000});
        step_s(1'b0, 32'h0);
        check("gap_pulse_end", {vout_s, fd_s, dout_s}, {2'b00, 32'h40400000});

        // mid-frame reset: partial frame dropped, next sample is (0,0)
        step_s(1'b1, 32'h41200000);
        step_s(1'b1, 32'h41200000);
        rst_s = 1'b0;
        #1;
        check("midreset_clear", {vout_s, fd_s, dout_s}, 34'h0);
        step_s(1'b0, 32'h0);
        rst_s = 1'b1;
        step_s(1'b1, 32'h3F800000);
        step_s(1'b1, 32'h00000000);
        step_s(1'b1, 32'h00000000);
        check("midreset_no_early", {vout_s, fd_s, dout_s}, 34'h0);
        step_s(1'b1, 32'h00000000);
        check("midreset_out", {vout_s, fd_s, dout_s}, {2'b11, 32'h3F800000});

        // full-size frame, valid_in always high
        for (int i = 0; i < BW * BH; i++) step_b(1'b1);
        check("frame1_count", {2'b00, 32'(out_cnt)}, {2'b00, 32'd3136});
        check("frame1_done", {2'b00, 32'(fd_cnt)}, {2'b00, 32'd1});

        // same frame with random idle cycles
        out_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < BW * BH; i++) begin
            while ($urandom_range(0, 99) < 40) step_b(1'b0);
            step_b(1'b1);
        end
        check("gaps_count", {2'b00, 32'(out_cnt)}, {2'b00, 32'd3136});
        check("gaps_done", {2'b00, 32'(fd_cnt)}, {2'b00, 32'd1});

        // reset at row 37 col 50, then two fresh frames back to back
        for (int i = 0; i < 37 * BW + 50; i++) step_b(1'b1);
        rst_b = 1'b0;
        #1;
        check("big_midreset", {vout_b, fd_b, dout_b}, 34'h0);
        vin_b = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        brow = 0; bcol = 0; exp_b = '0;
        out_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 2 * BW * BH; i++) step_b(1'b1);
        check("b2b_count", {2'b00, 32'(out_cnt)}, {2'b00, 32'd6272});
        check("b2b_done", {2'b00, 32'(fd_cnt)}, {2'b00, 32'd2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
